// File: rtl/bit_pair_scheduler.sv
// Walks every (weight bit, activation bit) pair of set bits in an 8-bit operand
// pair and emits one SumExps = i + j beat per pair over a valid/ready handshake.
module bit_pair_scheduler (
   input  logic       Clk,
   input  logic       RstN,
   input  logic       InValid,
   output logic       InReady,
   input  logic [7:0] Weight,
   input  logic [7:0] Activation,
   input  logic       Flush,
   output logic       OutValid,
   input  logic       OutReady,
   output logic [3:0] SumExps,
   output logic       OutLast,
   output logic       OutEmpty,
   output logic       Busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     state;
   logic [7:0] w_rem;
   logic [7:0] a_rem;
   logic [7:0] a_orig;
   logic       empty_op;

   logic [2:0] w_idx;
   logic [2:0] a_idx;
   logic       w_one;
   logic       a_one;
   logic       last_beat;
   logic       running;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

   function automatic logic single_bit(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   assign w_idx     = lowest_set(w_rem);
   assign a_idx     = lowest_set(a_rem);
   assign w_one     = single_bit(w_rem);
   assign a_one     = single_bit(a_rem);
   assign last_beat = empty_op | (w_one & a_one);
   assign running   = (state == RUN);

   // Every output is a decode of registered state, so OutReady/InValid never
   // reach an output combinationally.
   assign InReady  = ~running;
   assign Busy     = running;
   assign OutValid = running;
   assign OutEmpty = running & empty_op;
   assign OutLast  = running & last_beat;
   assign SumExps  = (running && !empty_op) ? ({1'b0, w_idx} + {1'b0, a_idx}) : 4'd0;

   // NOTE: non-blocking assignments so every register reads pre-edge values.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state    <= IDLE;
         w_rem    <= 8'd0;
         a_rem    <= 8'd0;
         a_orig   <= 8'd0;
         empty_op <= 1'b0;
      end else if (Flush) begin
         state    <= IDLE;
         w_rem    <= 8'd0;
         a_rem    <= 8'd0;
         a_orig   <= 8'd0;
         empty_op <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  w_rem    <= Weight;
                  a_rem    <= Activation;
                  a_orig   <= Activation;
                  empty_op <= (Weight == 8'd0) || (Activation == 8'd0);
                  state    <= RUN;
               end
            end
            RUN: begin
               if (OutReady) begin
                  if (last_beat) begin
                     state <= IDLE;
                  end else if (a_one) begin
                     // Inner activation loop exhausted: advance to next weight bit.
                     w_rem <= w_rem & (w_rem - 8'd1);
                     a_rem <= a_orig;
                  end else begin
                     a_rem <= a_rem & (a_rem - 8'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/bit_pair_scheduler.md
# bit_pair_scheduler

Sequencer that feeds the PE's one-hot exponent datapath. It accepts one 8-bit weight/activation pair and walks every pair of set bits (weight bit i, activation bit j). For each pair it emits one SumExps = i + j beat (0..14, 4 bits) to the CreateOneHotVector stage. Zero bits cost no cycles, which realises the bit-sparsity speed-up. Each beat moves over a valid/ready handshake, and the final beat of an operation is flagged.

## Interface
- Parameters: none. Operand width is fixed at 8 bits; max SumExps = 7+7 = 14 fits 4 bits.
- Clk  in  1  clock; all state updates on rising edge.
- RstN  in  1  asynchronous, active-low reset.
- InValid  in  1  operand pair valid.
- InReady  out  1  scheduler can accept a pair (high only in IDLE).
- Weight  in  8  unsigned weight magnitude, sampled on input handshake.
- Activation  in  8  unsigned activation magnitude, sampled on input handshake.
- Flush  in  1  synchronous abort of the current operation.
- OutValid  out  1  SumExps beat valid.
- OutReady  in  1  downstream accepts beat.
- SumExps  out  4  weight bit index + activation bit index for the current beat.
- OutLast  out  1  current beat is the final beat of the operation (qualified by OutValid).
- OutEmpty  out  1  operation has no terms (Weight==0 or Activation==0); beat carries SumExps=0.
- Busy  out  1  state != IDLE.

## Operation
- State registers:
  - `State` ∈ {IDLE, RUN}.
  - `WRem[7:0]`: weight bits not yet completed.
  - `ARem[7:0]`: activation bits remaining for the current weight bit.
  - `AOrig[7:0]`: captured activation.
  - `EmptyOp`: operation has no terms.
- Combinational outputs:
  - `WIdx` = index of lowest set bit of WRem; `AIdx` = lowest set bit of ARem. Each encoder returns 0 for an all-zero input.
  - SumExps = WIdx + AIdx, zero-extended to 4 bits, forced to 0 when EmptyOp.
- IDLE:
  - InReady=1, OutValid=0.
  - On InValid & InReady: WRem<=Weight, ARem<=Activation, AOrig<=Activation, EmptyOp<=(Weight==0 | Activation==0); go to RUN.
- RUN:
  - InReady=0, OutValid=1.
  - OutEmpty=EmptyOp.
  - OutLast = EmptyOp | (ARem has exactly one bit set & WRem has exactly one bit set).
- Beat accepted (OutValid & OutReady) in RUN:
  - If OutLast: go to IDLE.
  - Else if ARem has one bit set: clear lowest set bit of WRem; ARem<=AOrig.
  - Else: clear lowest set bit of ARem.
- Beat order: weight bits LSB-first (outer loop), activation bits LSB-first (inner loop).
- Beat count per operation: popcount(W)*popcount(A), or exactly 1 when EmptyOp.
- Stall: while OutValid & !OutReady, SumExps/OutLast/OutEmpty hold stable and no state changes.
- Flush:
  - Has priority over any handshake in the same cycle.
  - Next state is IDLE; WRem/ARem/AOrig/EmptyOp are cleared.
  - In IDLE, Flush also suppresses input capture that cycle.
- Reset (RstN low, asynchronous):
  - State=IDLE, all registers 0.
  - Outputs: OutValid=0, SumExps=0, OutLast=0, OutEmpty=0, Busy=0, InReady=1.
  - Reset mid-operation discards the operation, with no partial beats afterward.

## Timing
- Input capture edge N → first beat valid in cycle N+1 (latency 1).
- Sustained throughput: 1 beat/cycle with OutReady held high.
- Operation duration with no stalls: 1 (capture) + beats.
- Last beat accepted at edge M → State=IDLE, InReady=1 in cycle M+1. There is one bubble cycle between operations; no overlap with the next input.
- OutValid/OutLast/OutEmpty/SumExps are decoded from registered state only. There is no combinational path from OutReady or InValid to any output. InReady depends on State only.
- Flush asserted in cycle K → OutValid=0, InReady=1 in cycle K+1.

## Test plan
- W=0x05, A=0x03, OutReady=1 → 4 consecutive beats SumExps 0,1,2,3. OutLast only on beat 4. InReady returns 1 one cycle later.
- W=0x00, A=0xFF → exactly 1 beat: OutEmpty=1, OutLast=1, SumExps=0. A repeat with W=0x3C, A=0x00 gives the same result.
- W=0xFF, A=0xFF → exactly 64 beats. First SumExps=0, last=14 with OutLast. The histogram of SumExps values matches the convolution counts (1,2,…,8,…,2,1).
- W=0x80, A=0x81 with OutReady toggled 1-0-0-1 → beats 7 then 14. Values are held stable across stall cycles, with no duplicated or dropped beats.
- W=0xFF, A=0x01, assert Flush after 2 accepted beats (SumExps 0,1) → OutValid=0 and InReady=1 next cycle. A following W=0x02, A=0x02 yields a single beat SumExps=2 with OutLast.
- Assert RstN low mid-operation (W=0xF0, A=0x0F, after 3 beats) → immediately OutValid=0, Busy=0, SumExps=0, InReady=1. After release, the next operation runs normally.
